// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lif_pkg
//  Description : Shared constants and helpers for the LIF neuron array.
//  Revision    : 1.0 - initial release
// ============================================================================
package lif_pkg;

   // Post-fire behaviour selectors for RESET_MODE
   localparam int RESET_ZERO = 0;
   localparam int RESET_SUB  = 1;

   // Channel-index width; never narrower than one bit
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lif_update_unit.sv
`default_nettype none
// ============================================================================
//  Module      : lif_update_unit
//  Description : Combinational leak / integrate / saturate / fire datapath
//                for a single neuron. A high 'block' forces a refractory
//                visit: state 0, no fire.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_update_unit
   import lif_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int LEAK_SHIFT = 1,
   parameter int RESET_MODE = RESET_ZERO
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] current,
   input  logic [WIDTH-1:0] threshold,
   input  logic             block,
   output logic [WIDTH-1:0] new_state,
   output logic             fire
);

   logic [WIDTH-1:0] w_leak;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_sat;
   logic             w_hit;

   // Leak never underflows: subtracting a right-shifted copy of itself
   assign w_leak = state - (state >> LEAK_SHIFT);
   // One extra bit catches the carry so the sum can clamp to full scale
   assign w_sum  = {1'b0, w_leak} + {1'b0, current};
   assign w_sat  = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
   // A zero threshold disables firing entirely
   assign w_hit  = (threshold != '0) && (w_sat >= threshold);
   assign fire   = w_hit && !block;

   // Select the post-update membrane state
   always_comb begin
      new_state = w_sat;
      if (block) begin
         new_state = '0;
      end else if (w_hit) begin
         if (RESET_MODE == RESET_SUB) begin
            new_state = w_sat - threshold;
         end else begin
            new_state = '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : lif_neuron_array
//  Description : NUM_CH leaky integrate-and-fire neurons sharing one update
//                datapath, visited round-robin one channel per enabled cycle.
//                Optional per-channel refractory counters are built when the
//                LIF_REFRAC_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron_array
   import lif_pkg::*;
#(
   parameter int NUM_CH     = 8,
   parameter int WIDTH      = 8,
   parameter int LEAK_SHIFT = 1,
   parameter int RESET_MODE = RESET_ZERO,
   parameter int REFRAC_LEN = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [NUM_CH*WIDTH-1:0]     current,
   input  logic [WIDTH-1:0]            threshold,
   output logic [NUM_CH-1:0]           spike,
   output logic [WIDTH-1:0]            state_mon,
   output logic [ch_idx_w(NUM_CH)-1:0] mon_ch,
   output logic                        frame_done
);

   localparam int            PW     = ch_idx_w(NUM_CH);
   localparam logic [PW-1:0] c_last = PW'(NUM_CH - 1);

   logic [WIDTH-1:0] w_cur [NUM_CH];
   logic [WIDTH-1:0] r_state [NUM_CH];
   logic [PW-1:0]    r_ptr;
   logic [WIDTH-1:0] w_new_state;
   logic             w_fire;
   logic             w_block;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign w_cur[i] = current[i*WIDTH +: WIDTH];
   end

`ifdef LIF_REFRAC_EN
   localparam int RW = (REFRAC_LEN > 0) ? $clog2(REFRAC_LEN + 1) : 1;

   logic [RW-1:0] r_refrac [NUM_CH];

   assign w_block = (r_refrac[r_ptr] != '0);

   // Count down a blocked channel's refractory period, reload it on fire
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) r_refrac[i] <= '0;
      end else if (en) begin
         if (w_block) begin
            r_refrac[r_ptr] <= r_refrac[r_ptr] - 1'b1;
         end else if (w_fire) begin
            r_refrac[r_ptr] <= RW'(REFRAC_LEN);
         end
      end
   end
`else
   assign w_block = 1'b0;
`endif

   lif_update_unit #(
      .WIDTH      (WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .RESET_MODE (RESET_MODE)
   ) u_update (
      .state      (r_state[r_ptr]),
      .current    (w_cur[r_ptr]),
      .threshold  (threshold),
      .block      (w_block),
      .new_state  (w_new_state),
      .fire       (w_fire)
   );

   // Write back the visited channel, register outputs and advance the pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) r_state[i] <= '0;
         r_ptr      <= '0;
         spike      <= '0;
         state_mon  <= '0;
         mon_ch     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= en && (r_ptr == c_last);
         if (en) begin
            r_state[r_ptr] <= w_new_state;
            spike[r_ptr]   <= w_fire;
            state_mon      <= w_new_state;
            mon_ch         <= r_ptr;
            r_ptr          <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lif_neuron_array
//  Description : Self-checking bench for lif_neuron_array. Two instances
//                (reset-to-zero and subtract-threshold) share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron_array;

   localparam int N = 8;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [N*W-1:0] current;
   logic [W-1:0]   threshold;
   logic [N-1:0]   spike0, spike1;
   logic [W-1:0]   mon0, mon1;
   logic [2:0]     ch0, ch1;
   logic           fd0, fd1;

   always #5 clk = ~clk;

   lif_neuron_array #(.NUM_CH(N), .WIDTH(W), .LEAK_SHIFT(1), .RESET_MODE(0), .REFRAC_LEN(2)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .current(current), .threshold(threshold),
      .spike(spike0), .state_mon(mon0), .mon_ch(ch0), .frame_done(fd0));

   lif_neuron_array #(.NUM_CH(N), .WIDTH(W), .LEAK_SHIFT(1), .RESET_MODE(1), .REFRAC_LEN(2)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .current(current), .threshold(threshold),
      .spike(spike1), .state_mon(mon1), .mon_ch(ch1), .frame_done(fd1));

   typedef struct {
      int           ch;
      int           st0;
      int           st1;
      logic [N-1:0] sp0;
      logic [N-1:0] sp1;
      bit           fd;
   } exp_t;

   typedef struct {
      int cur;
      int thr;
      int visits;
      int exp0;
      int exp1;
      int spk;
   } vec_t;

   exp_t         sb[$];
   exp_t         last;
   int           m_st0[N], m_st1[N], m_rf0[N], m_rf1[N];
   int           m_ptr;
   logic [N-1:0] m_sp0, m_sp1;
   int           checks   = 0;
   int           failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference neuron update (LEAK_SHIFT=1, WIDTH=8, REFRAC_LEN=2)
   function automatic void model_upd(input int s, input int cur, input int thr, input int mode,
                                     inout int rf, output int ns, output bit f);
      int sum;
`ifdef LIF_REFRAC_EN
      if (rf != 0) begin
         rf = rf - 1;
         ns = 0;
         f  = 1'b0;
         return;
      end
`endif
      sum = s - s / 2 + cur;
      if (sum > 255) sum = 255;
      f  = (thr != 0) && (sum >= thr);
      ns = f ? ((mode == 1) ? sum - thr : 0) : sum;
`ifdef LIF_REFRAC_EN
      if (f) rf = 2;
`endif
   endfunction

   // One clock: predict and enqueue on enabled cycles, then check all outputs
   task automatic cycle();
      exp_t e;
      int   cur, ns, rf;
      bit   f;
      if (en) begin
         cur = int'(current[m_ptr*W +: W]);
         rf  = m_rf0[m_ptr];
         model_upd(m_st0[m_ptr], cur, int'(threshold), 0, rf, ns, f);
         m_rf0[m_ptr] = rf; m_st0[m_ptr] = ns; m_sp0[m_ptr] = f;
         rf  = m_rf1[m_ptr];
         model_upd(m_st1[m_ptr], cur, int'(threshold), 1, rf, ns, f);
         m_rf1[m_ptr] = rf; m_st1[m_ptr] = ns; m_sp1[m_ptr] = f;
         e.ch  = m_ptr;
         e.st0 = m_st0[m_ptr];
         e.st1 = m_st1[m_ptr];
         e.sp0 = m_sp0;
         e.sp1 = m_sp1;
         e.fd  = (m_ptr == N - 1);
         sb.push_back(e);
         m_ptr = (m_ptr + 1) % N;
      end
      @(posedge clk);
      #1;
      if (sb.size() != 0) last = sb.pop_front();
      else                last.fd = 1'b0;
      chk("mon_ch0",     32'(ch0),    32'(last.ch));
      chk("state_mon0",  32'(mon0),   32'(last.st0));
      chk("spike0",      32'(spike0), 32'(last.sp0));
      chk("frame_done0", 32'(fd0),    32'(last.fd));
      chk("mon_ch1",     32'(ch1),    32'(last.ch));
      chk("state_mon1",  32'(mon1),   32'(last.st1));
      chk("spike1",      32'(spike1), 32'(last.sp1));
      chk("frame_done1", 32'(fd1),    32'(last.fd));
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic set_cur(input int ch, input int val);
      current[ch*W +: W] = W'(val);
   endtask

   // Asynchronous reset pulse; outputs must clear without waiting for a clock
   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         m_st0[i] = 0; m_st1[i] = 0; m_rf0[i] = 0; m_rf1[i] = 0;
      end
      m_ptr = 0; m_sp0 = '0; m_sp1 = '0;
      sb.delete();
      last = '{ch: 0, st0: 0, st1: 0, sp0: '0, sp1: '0, fd: 1'b0};
      #1;
      chk("rst_state_mon", 32'(mon0),   32'd0);
      chk("rst_mon_ch",    32'(ch0),    32'd0);
      chk("rst_spike",     32'(spike0), 32'd0);
      chk("rst_frame",     32'(fd0),    32'd0);
      chk("rst_state_mon1", 32'(mon1),  32'd0);
      chk("rst_spike1",    32'(spike1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   vec_t tbl[11];
   int   fd_count;
   bit   exp_spk6[6];

   initial begin
      rst = 1'b1; en = 1'b0; current = '0; threshold = '0;
      @(negedge clk);

      // ch0 trajectories at threshold 100: {current, thr, visit, mode0, mode1, spike}
      tbl[0]  = '{40, 100, 1, 40, 40, 0};
      tbl[1]  = '{40, 100, 2, 60, 60, 0};
      tbl[2]  = '{40, 100, 3, 70, 70, 0};
      tbl[3]  = '{40, 100, 4, 75, 75, 0};
      tbl[4]  = '{40, 100, 5, 78, 78, 0};
      tbl[5]  = '{40, 100, 6, 79, 79, 0};
      tbl[6]  = '{40, 100, 7, 80, 80, 0};
      tbl[7]  = '{40, 100, 8, 80, 80, 0};
      tbl[8]  = '{60, 100, 1, 60, 60, 0};
      tbl[9]  = '{60, 100, 2, 90, 90, 0};
      tbl[10] = '{60, 100, 3,  0,  5, 1};

      for (int i = 0; i < 11; i++) begin
         do_reset();
         current = '0;
         set_cur(0, tbl[i].cur);
         threshold = W'(tbl[i].thr);
         en = 1'b1;
         run((tbl[i].visits - 1) * N + 1);
         chk($sformatf("tbl%0d_ch", i),     32'(ch0),       32'd0);
         chk($sformatf("tbl%0d_state0", i), 32'(mon0),      32'(tbl[i].exp0));
         chk($sformatf("tbl%0d_state1", i), 32'(mon1),      32'(tbl[i].exp1));
         chk($sformatf("tbl%0d_spike", i),  32'(spike0[0]), 32'(tbl[i].spk));
      end

      // Saturation with firing disabled on ch3
      do_reset();
      current = '0; threshold = '0; en = 1'b1;
      set_cur(3, 200);
      run(4);
      chk("sat_pre_state", 32'(mon0), 32'd200);
      chk("sat_pre_ch",    32'(ch0),  32'd3);
      set_cur(3, 255);
      run(N);
      chk("sat_state",  32'(mon0),      32'd255);
      chk("sat_state1", 32'(mon1),      32'd255);
      chk("sat_ch",     32'(ch0),       32'd3);
      chk("sat_spike",  32'(spike0[3]), 32'd0);

      // Freeze at ptr=4, then resume
      do_reset();
      threshold = 8'd100; en = 1'b1;
      for (int i = 0; i < N; i++) set_cur(i, 10 * i + 5);
      run(4);
      en = 1'b0;
      run(5);
      chk("hold_mon_ch", 32'(ch0), 32'd3);
      en = 1'b1;
      run(1);
      chk("resume_ch", 32'(ch0), 32'd4);

      // Mid-sweep reset at ptr=5 with nonzero states
      do_reset();
      run(1);
      chk("post_rst_ch",    32'(ch0),  32'd0);
      chk("post_rst_state", 32'(mon0), 32'd5);
      fd_count = 0;
      for (int k = 0; k < 16; k++) begin
         cycle();
         if (fd0) fd_count++;
      end
      chk("frame_done_count", 32'(fd_count), 32'd2);

      // Repeated firing of ch0 with and without refractory counters
`ifdef LIF_REFRAC_EN
      exp_spk6 = '{1, 0, 0, 1, 0, 0};
`else
      exp_spk6 = '{1, 1, 1, 1, 1, 1};
`endif
      do_reset();
      current = '0; threshold = 8'd100; en = 1'b1;
      set_cur(0, 120);
      for (int v = 0; v < 6; v++) begin
         run((v == 0) ? 1 : N);
         chk($sformatf("refrac_v%0d_ch", v + 1),    32'(ch0),       32'd0);
         chk($sformatf("refrac_v%0d_spike", v + 1), 32'(spike0[0]), 32'(exp_spk6[v]));
         chk($sformatf("refrac_v%0d_state", v + 1), 32'(mon0),      32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
